// File: rtl/gpio_bank_if.sv
// Register-access bus between the MIPS data path and the GPIO bank.
interface gpio_bank_if;
  logic [3:0]  i_ADDR;
  logic        i_WE;
  logic        i_RE;
  logic [31:0] i_DATA;
  logic [31:0] o_RDATA;

  modport master (output i_ADDR, i_WE, i_RE, i_DATA, input o_RDATA);
  modport slave  (input  i_ADDR, i_WE, i_RE, i_DATA, output o_RDATA);
endinterface

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: direction/output registers with atomic set/clear/
// toggle, per-pin alternate-function routing, synchronised inputs and a
// level interrupt on enabled rising/falling pin edges.
module gpio_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_arst,
  gpio_bank_if.slave        bus,
  input  logic [WIDTH-1:0]  i_ALT_IN,
  inout  wire  [WIDTH-1:0]  io_IO,
  output logic              o_IRQ
);

  logic [WIDTH-1:0] ddir_q,   ddir_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic [WIDTH-1:0] altsel_q, altsel_d;
  logic [WIDTH-1:0] rise_q,   rise_d;
  logic [WIDTH-1:0] fall_q,   fall_d;
  logic [WIDTH-1:0] irq_q,    irq_d;
  logic [31:0]      rdata_q,  rdata_d;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] irq_set;
  logic [WIDTH-1:0] irq_clr;
  logic [31:0]      rd_val;
  logic             unused_data;

  assign din         = sync_q[SYNC_STAGES-1];
  assign wdata       = bus.i_DATA[WIDTH-1:0];
  assign unused_data = ^bus.i_DATA;
  assign bus.o_RDATA = rdata_q;
  assign o_IRQ       = |irq_q;

  // Edge events gated by the enables currently held in the registers.
  assign irq_set = ((din & ~prev_q) & rise_q) | ((~din & prev_q) & fall_q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign io_IO[i] = ddir_q[i] ? (altsel_q[i] ? i_ALT_IN[i] : dout_q[i]) : 1'bz;
  end

  // Input synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= io_IO;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= din;
    end
  end

  // Read mux: registers zero-extended to the 32-bit bus; write-only and
  // reserved addresses read as zero.
  always_comb begin
    rd_val = '0;
    case (bus.i_ADDR)
      4'd0:    rd_val[WIDTH-1:0] = ddir_q;
      4'd1:    rd_val[WIDTH-1:0] = dout_q;
      4'd5:    rd_val[WIDTH-1:0] = din;
      4'd6:    rd_val[WIDTH-1:0] = altsel_q;
      4'd7:    rd_val[WIDTH-1:0] = rise_q;
      4'd8:    rd_val[WIDTH-1:0] = fall_q;
      4'd9:    rd_val[WIDTH-1:0] = irq_q;
      default: rd_val = '0;
    endcase
  end

  // Next-state for bus-visible registers; a hardware set on IRQ_STAT is
  // OR-ed after the W1C mask so it wins over a same-cycle clear.
  always_comb begin
    ddir_d   = ddir_q;
    dout_d   = dout_q;
    altsel_d = altsel_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    irq_clr  = '0;
    rdata_d  = rdata_q;
    if (bus.i_WE) begin
      case (bus.i_ADDR)
        4'd0:    ddir_d   = wdata;
        4'd1:    dout_d   = wdata;
        4'd2:    dout_d   = dout_q | wdata;
        4'd3:    dout_d   = dout_q & ~wdata;
        4'd4:    dout_d   = dout_q ^ wdata;
        4'd6:    altsel_d = wdata;
        4'd7:    rise_d   = wdata;
        4'd8:    fall_d   = wdata;
        4'd9:    irq_clr  = wdata;
        default: ;
      endcase
    end
    irq_d = (irq_q & ~irq_clr) | irq_set;
    if (bus.i_RE) rdata_d = rd_val;
  end

  // Register bank; reset overrides any same-cycle access.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      ddir_q   <= '0;
      dout_q   <= '0;
      altsel_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_q    <= '0;
      rdata_q  <= '0;
    end else begin
      ddir_q   <= ddir_d;
      dout_q   <= dout_d;
      altsel_q <= altsel_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: one 32-pin/2-stage instance and one
// 8-pin/3-stage instance sharing a clock and reset.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] altA;
  logic [7:0]  altB;
  logic [31:0] oeA, valA;
  logic [7:0]  oeB, valB;
  logic        irqA, irqB;
  wire  [31:0] pinsA;
  wire  [7:0]  pinsB;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gpio_bank_if busA ();
  gpio_bank_if busB ();

  gpio_bank #(.WIDTH(32), .SYNC_STAGES(2)) dutA (
    .i_clk(clk), .i_arst(arst), .bus(busA), .i_ALT_IN(altA), .io_IO(pinsA), .o_IRQ(irqA)
  );

  gpio_bank #(.WIDTH(8), .SYNC_STAGES(3)) dutB (
    .i_clk(clk), .i_arst(arst), .bus(busB), .i_ALT_IN(altB), .io_IO(pinsB), .o_IRQ(irqB)
  );

  for (genvar i = 0; i < 32; i++) begin : g_drvA
    assign pinsA[i] = oeA[i] ? valA[i] : 1'bz;
  end
  for (genvar i = 0; i < 8; i++) begin : g_drvB
    assign pinsB[i] = oeB[i] ? valB[i] : 1'bz;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wrA(input logic [3:0] a, input logic [31:0] d);
    busA.i_ADDR = a; busA.i_DATA = d; busA.i_WE = 1'b1;
    cyc(1);
    busA.i_WE = 1'b0;
  endtask

  task automatic rdA(input logic [3:0] a, input logic [31:0] exp, input string tag);
    busA.i_ADDR = a; busA.i_RE = 1'b1;
    cyc(1);
    busA.i_RE = 1'b0;
    chk(tag, busA.o_RDATA, exp);
  endtask

  task automatic wrB(input logic [3:0] a, input logic [31:0] d);
    busB.i_ADDR = a; busB.i_DATA = d; busB.i_WE = 1'b1;
    cyc(1);
    busB.i_WE = 1'b0;
  endtask

  task automatic rdB(input logic [3:0] a, input logic [31:0] exp, input string tag);
    busB.i_ADDR = a; busB.i_RE = 1'b1;
    cyc(1);
    busB.i_RE = 1'b0;
    chk(tag, busB.o_RDATA, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    arst = 1'b1;
    altA = '0; altB = '0;
    oeA = '1; valA = '0;
    oeB = '1; valB = '0;
    busA.i_ADDR = '0; busA.i_WE = 1'b0; busA.i_RE = 1'b0; busA.i_DATA = '0;
    busB.i_ADDR = '0; busB.i_WE = 1'b0; busB.i_RE = 1'b0; busB.i_DATA = '0;
    cyc(3);
    arst = 1'b0;

    // Reset state
    chk("rst_rdata", busA.o_RDATA, 32'h0);
    chk("rst_irq", {31'h0, irqA}, 32'h0);
    for (int a = 0; a < 16; a++) rdA(4'(a), 32'h0, $sformatf("rst_rd%0d", a));
    valA = 32'h1234_5678;
    cyc(4);
    rdA(4'd5, 32'h1234_5678, "rst_pins_z");
    chk("rst_rise_masked", {31'h0, irqA}, 32'h0);
    rdA(4'd9, 32'h0, "rst_stat_masked");

    // Output register with set/clear/toggle
    valA = '0;
    cyc(3);
    wrA(4'd0, 32'h0000_FFFF);
    oeA = 32'hFFFF_0000; valA = 32'hA5A5_0000;
    wrA(4'd1, 32'h0000_00F0);
    wrA(4'd2, 32'h0000_0003);
    wrA(4'd3, 32'h0000_0010);
    wrA(4'd4, 32'h0000_0101);
    rdA(4'd1, 32'h0000_01E2, "dout_atomic");
    chk("pins_low", {16'h0, pinsA[15:0]}, 32'h0000_01E2);
    rdA(4'd2, 32'h0, "rd_set_zero");
    rdA(4'd4, 32'h0, "rd_tgl_zero");
    cyc(2);
    rdA(4'd5, 32'hA5A5_01E2, "din_upper_z");

    // Read and write same address in the same cycle
    busA.i_ADDR = 4'd1; busA.i_DATA = 32'h55; busA.i_WE = 1'b1; busA.i_RE = 1'b1;
    cyc(1);
    busA.i_WE = 1'b0; busA.i_RE = 1'b0;
    chk("rw_prewrite", busA.o_RDATA, 32'h0000_01E2);
    rdA(4'd1, 32'h55, "rw_postwrite");

    // Alternate function routing on pin 0
    wrA(4'd6, 32'h1);
    chk("alt_lo", {31'h0, pinsA[0]}, 32'h0);
    altA[0] = 1'b1; #1;
    chk("alt_hi", {31'h0, pinsA[0]}, 32'h1);
    altA[0] = 1'b0; #1;
    chk("alt_lo2", {31'h0, pinsA[0]}, 32'h0);
    wrA(4'd6, 32'h0);
    chk("alt_off_dout", {31'h0, pinsA[0]}, 32'h1);

    // Rising edge interrupt, latency with 2 sync stages
    wrA(4'd0, 32'h0);
    oeA = '1; valA = '0;
    cyc(4);
    wrA(4'd7, 32'h4);
    rdA(4'd9, 32'h0, "stat_idle");
    valA[2] = 1'b1;
    cyc(1);
    chk("irq_k", {31'h0, irqA}, 32'h0);
    cyc(1);
    chk("irq_k1", {31'h0, irqA}, 32'h0);
    busA.i_ADDR = 4'd5; busA.i_RE = 1'b1;
    cyc(1);
    busA.i_RE = 1'b0;
    chk("din_k1", busA.o_RDATA, 32'h4);
    chk("irq_k2", {31'h0, irqA}, 32'h1);
    rdA(4'd9, 32'h4, "stat_rise");
    wrA(4'd9, 32'h4);
    chk("irq_cleared", {31'h0, irqA}, 32'h0);
    valA[2] = 1'b0;
    cyc(4);
    rdA(4'd9, 32'h0, "fall_masked");

    // Same-cycle W1C and set: set wins, other bits clear
    wrA(4'd7, 32'hC);
    valA[3] = 1'b1;
    cyc(4);
    rdA(4'd9, 32'h8, "stat_pin3");
    valA[2] = 1'b1;
    cyc(2);
    busA.i_ADDR = 4'd9; busA.i_DATA = 32'hC; busA.i_WE = 1'b1;
    cyc(1);
    busA.i_WE = 1'b0;
    rdA(4'd9, 32'h4, "set_wins");
    chk("irq_set_wins", {31'h0, irqA}, 32'h1);
    wrA(4'd9, 32'h4);
    rdA(4'd9, 32'h0, "w1c_plain");
    chk("irq_w1c", {31'h0, irqA}, 32'h0);

    // Reset overrides pending write and read
    busA.i_ADDR = 4'd1; busA.i_DATA = 32'hAB; busA.i_WE = 1'b1; busA.i_RE = 1'b1;
    arst = 1'b1;
    cyc(1);
    arst = 1'b0; busA.i_WE = 1'b0; busA.i_RE = 1'b0;
    chk("mid_rst_rdata", busA.o_RDATA, 32'h0);
    chk("mid_rst_irq", {31'h0, irqA}, 32'h0);
    rdA(4'd1, 32'h0, "mid_rst_dout");
    rdA(4'd7, 32'h0, "mid_rst_rise");
    cyc(3);
    rdA(4'd9, 32'h0, "mid_rst_stat");

    // 8-pin, 3-stage instance
    wrB(4'd6, 32'hFFFF_FFAA);
    rdB(4'd6, 32'hAA, "b_upper_ignored");
    wrB(4'd6, 32'h0);
    wrB(4'd1, 32'hFFFF_FF3C);
    rdB(4'd1, 32'h3C, "b_dout");
    rdB(4'd12, 32'h0, "b_reserved");
    wrB(4'd7, 32'h1);
    valB[0] = 1'b1;
    cyc(3);
    chk("b_irq_k2", {31'h0, irqB}, 32'h0);
    cyc(1);
    chk("b_irq_k3", {31'h0, irqB}, 32'h1);
    rdB(4'd9, 32'h1, "b_stat");
    rdB(4'd5, 32'h1, "b_din");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
